// File: rtl/spin_pattern_gen.sv
// Switch-driven "spinning square" source for the 4-digit seven-segment path.
// Synchronises and debounces run/direction switches, then steps an 8-position pattern.
module spin_pattern_gen #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_en,
    input  logic        sw_dir,
    output logic        en_o,
    output logic        dir_o,
    output logic        step,
    output logic [2:0]  pos,
    output logic [31:0] digits
);
    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam int PW  = $clog2(TICK_DIV);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [31:0]    DIGITS_RESET = 32'h9CFFFFFF;

    // Index 0 carries the run switch, index 1 the direction switch.
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [DBW-1:0] db_cnt [2];
    logic [1:0]     db_val;
    logic [PW-1:0]  presc;
    logic [2:0]     next_pos;

    function automatic logic [31:0] decode(input logic [2:0] p);
        logic [31:0] d;
        d = '1;
        case (p)
            3'd0: d[31:24] = 8'h9C;
            3'd1: d[23:16] = 8'h9C;
            3'd2: d[15:8]  = 8'h9C;
            3'd3: d[7:0]   = 8'h9C;
            3'd4: d[7:0]   = 8'hA3;
            3'd5: d[15:8]  = 8'hA3;
            3'd6: d[23:16] = 8'hA3;
            default: d[31:24] = 8'hA3;
        endcase
        return d;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            db_val    <= '0;
        end else begin
            sync1 <= {sw_dir, sw_en};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_val[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_val[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign en_o     = db_val[0];
    assign dir_o    = db_val[1];
    assign next_pos = dir_o ? pos - 3'd1 : pos + 3'd1;

    // Uses pre-edge en_o/dir_o, so a step on the same edge as a level change completes with old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            step   <= 1'b0;
            pos    <= 3'd0;
            digits <= DIGITS_RESET;
        end else begin
            step <= 1'b0;
            if (en_o) begin
                if (presc == PRE_LAST) begin
                    presc  <= '0;
                    step   <= 1'b1;
                    pos    <= next_pos;
                    digits <= decode(next_pos);
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spin_pattern_gen.sv
// Bench for spin_pattern_gen: directed scenarios plus random switch activity,
// checked against a window/arithmetic reference model of the switch path and pattern.
module tb_spin_pattern_gen;
    localparam int TICK = 4;
    localparam int DB   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sw_en = 1'b0;
    logic        sw_dir = 1'b0;
    logic        en_o, dir_o, step;
    logic [2:0]  pos;
    logic [31:0] digits;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spin_pattern_gen #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .sw_en(sw_en), .sw_dir(sw_dir),
        .en_o(en_o), .dir_o(dir_o), .step(step), .pos(pos), .digits(digits)
    );

    // Reference model: a level is accepted once the last DB synchronised samples all disagree with it.
    logic       m_en, m_dir, m_step;
    logic [2:0] m_pos;
    int         m_phase;
    bit         en_raw_q[$], dir_raw_q[$], en_s_q[$], dir_s_q[$];
    bit         s_en, s_dir, nxt_en, nxt_dir, all_diff;

    function automatic logic [31:0] exp_digits(input int p);
        logic [31:0] d;
        int idx;
        d = '1;
        idx = (p < 4) ? (3 - p) : (p - 4);
        d[idx*8 +: 8] = (p < 4) ? 8'h9C : 8'hA3;
        return d;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_en = 0; m_dir = 0; m_step = 0; m_pos = 0; m_phase = 0;
            en_raw_q.delete(); dir_raw_q.delete(); en_s_q.delete(); dir_s_q.delete();
        end else begin
            en_raw_q.push_back(sw_en);
            dir_raw_q.push_back(sw_dir);
            s_en  = (en_raw_q.size() >= 3) ? en_raw_q[en_raw_q.size()-3] : 1'b0;
            s_dir = (dir_raw_q.size() >= 3) ? dir_raw_q[dir_raw_q.size()-3] : 1'b0;
            if (en_raw_q.size() > 3) en_raw_q.pop_front();
            if (dir_raw_q.size() > 3) dir_raw_q.pop_front();
            en_s_q.push_back(s_en);
            dir_s_q.push_back(s_dir);
            if (en_s_q.size() > DB) en_s_q.pop_front();
            if (dir_s_q.size() > DB) dir_s_q.pop_front();
            nxt_en = m_en;
            all_diff = (en_s_q.size() == DB);
            foreach (en_s_q[i]) if (en_s_q[i] == m_en) all_diff = 0;
            if (all_diff) begin nxt_en = ~m_en; en_s_q.delete(); end
            nxt_dir = m_dir;
            all_diff = (dir_s_q.size() == DB);
            foreach (dir_s_q[i]) if (dir_s_q[i] == m_dir) all_diff = 0;
            if (all_diff) begin nxt_dir = ~m_dir; dir_s_q.delete(); end
            m_step = 0;
            if (m_en) begin
                m_phase = (m_phase + 1) % TICK;
                if (m_phase == 0) begin
                    m_step = 1;
                    m_pos = 3'((int'(m_pos) + (m_dir ? 7 : 1)) % 8);
                end
            end
            m_en = nxt_en;
            m_dir = nxt_dir;
        end
    end

    task automatic test_reset();
        int nsteps = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (en_o !== 1'b0) $display("FAIL reset_en got=%b exp=0", en_o); else n_pass++;
        n_total++; if (pos !== 3'd0) $display("FAIL reset_pos got=%0d exp=0", pos); else n_pass++;
        n_total++; if (digits !== 32'h9CFFFFFF) $display("FAIL reset_digits got=%h exp=9cffffff", digits); else n_pass++;
        n_total++; if (step !== 1'b0) $display("FAIL reset_step got=%b exp=0", step); else n_pass++;
        reset = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (step === 1'b1) nsteps++;
            n_total++;
            if ({en_o, dir_o, step, pos, digits} !== {m_en, m_dir, m_step, m_pos, exp_digits(m_pos)})
                $display("FAIL idle_model got=%b%b%b %0d %h exp=%b%b%b %0d %h", en_o, dir_o, step, pos, digits,
                         m_en, m_dir, m_step, m_pos, exp_digits(m_pos));
            else n_pass++;
        end
        n_total++; if (nsteps != 0) $display("FAIL idle_steps got=%0d exp=0", nsteps); else n_pass++;
    endtask

    task automatic test_run();
        int edges = 0, since = -1, nsteps = 0;
        int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        @(negedge clk);
        sw_en = 1'b1;
        while (!en_o && edges < 20) begin @(posedge clk); #1; edges++; end
        n_total++; if (edges != 5) $display("FAIL run_en_latency got=%0d exp=5", edges); else n_pass++;
        repeat (40) begin
            @(negedge clk);
            since++;
            n_total++;
            if ({en_o, dir_o, step, pos, digits} !== {m_en, m_dir, m_step, m_pos, exp_digits(m_pos)})
                $display("FAIL run_model got=%b%b%b %0d %h exp=%b%b%b %0d %h", en_o, dir_o, step, pos, digits,
                         m_en, m_dir, m_step, m_pos, exp_digits(m_pos));
            else n_pass++;
            if (step === 1'b1) begin
                n_total++; if (since != 4) $display("FAIL run_step_gap got=%0d exp=4", since); else n_pass++;
                if (nsteps < 8) begin
                    n_total++;
                    if (pos !== 3'(exp_seq[nsteps]) || digits !== exp_digits(exp_seq[nsteps]))
                        $display("FAIL run_seq got=%0d %h exp=%0d %h", pos, digits, exp_seq[nsteps], exp_digits(exp_seq[nsteps]));
                    else n_pass++;
                end
                if (nsteps == 0) begin
                    n_total++; if (digits !== 32'hFF9CFFFF) $display("FAIL run_first_digits got=%h exp=ff9cffff", digits); else n_pass++;
                end
                if (nsteps == 7) begin
                    n_total++; if (digits !== 32'h9CFFFFFF) $display("FAIL run_wrap_digits got=%h exp=9cffffff", digits); else n_pass++;
                end
                nsteps++;
                since = 0;
            end
        end
        n_total++; if (nsteps < 8) $display("FAIL run_step_count got=%0d exp>=8", nsteps); else n_pass++;
    endtask

    task automatic test_dir();
        int k = 0, rise = -1, ns = 0;
        logic [2:0]  exp_p[3] = '{3'd7, 3'd6, 3'd5};
        logic [31:0] exp_d[3] = '{32'hA3FFFFFF, 32'hFFA3FFFF, 32'hFFFFA3FF};
        do begin @(negedge clk); k++; end while (!(step === 1'b1 && pos === 3'd7) && k < 40);
        n_total++; if (k >= 40) $display("FAIL dir_wait_pos7 got=timeout exp=pos7"); else n_pass++;
        sw_dir = 1'b1;
        k = 0;
        repeat (24) begin
            @(negedge clk);
            k++;
            if (dir_o === 1'b1 && rise < 0) rise = k;
            if (k == 4) begin
                n_total++; if (pos !== 3'd0) $display("FAIL dir_old_step got=%0d exp=0", pos); else n_pass++;
            end
            if (step === 1'b1 && dir_o === 1'b1 && ns < 3) begin
                n_total++;
                if (pos !== exp_p[ns] || digits !== exp_d[ns])
                    $display("FAIL dir_seq got=%0d %h exp=%0d %h", pos, digits, exp_p[ns], exp_d[ns]);
                else n_pass++;
                ns++;
            end
        end
        n_total++; if (rise != 5) $display("FAIL dir_latency got=%0d exp=5", rise); else n_pass++;
        n_total++; if (ns != 3) $display("FAIL dir_step_count got=%0d exp=3", ns); else n_pass++;
    endtask

    task automatic test_glitch();
        int k = 0;
        logic [2:0] p0;
        @(negedge clk);
        sw_en = 1'b0;
        while (en_o !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        n_total++; if (en_o !== 1'b0) $display("FAIL glitch_fall got=%b exp=0", en_o); else n_pass++;
        repeat (8) @(negedge clk);
        p0 = pos;
        sw_en = 1'b1;
        repeat (2) @(negedge clk);
        sw_en = 1'b0;
        repeat (15) begin
            @(negedge clk);
            n_total++;
            if ({en_o, pos} !== {1'b0, p0}) $display("FAIL glitch_hold got=%b %0d exp=0 %0d", en_o, pos, p0);
            else n_pass++;
        end
        sw_en = 1'b1;
        k = 0;
        while (en_o !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_total++; if (k != 5) $display("FAIL glitch_long_hold got=%0d exp=5", k); else n_pass++;
    endtask

    task automatic test_pause();
        int k = 0;
        logic [2:0]  p0;
        logic [31:0] d0;
        while (!(m_en && m_phase == 1) && k < 20) begin @(negedge clk); k++; end
        sw_en = 1'b0;
        k = 0;
        while (en_o !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        n_total++; if (k != 5) $display("FAIL pause_latency got=%0d exp=5", k); else n_pass++;
        p0 = pos;
        d0 = digits;
        repeat (100) begin
            @(negedge clk);
            n_total++;
            if ({step, pos, digits} !== {1'b0, p0, d0}) $display("FAIL pause_frozen got=%b %0d %h exp=0 %0d %h", step, pos, digits, p0, d0);
            else n_pass++;
        end
        sw_en = 1'b1;
        k = 0;
        while (en_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (step !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        n_total++; if (k != 2) $display("FAIL resume_step got=%0d exp=2", k); else n_pass++;
        n_total++; if (pos !== p0 - 3'd1) $display("FAIL resume_pos got=%0d exp=%0d", pos, p0 - 3'd1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        while (pos !== 3'd5 && k < 60) begin @(negedge clk); k++; end
        n_total++; if (pos !== 3'd5) $display("FAIL rst_wait_pos5 got=%0d exp=5", pos); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({en_o, step, pos, digits} !== {1'b0, 1'b0, 3'd0, 32'h9CFFFFFF})
            $display("FAIL rst_async got=%b %b %0d %h exp=0 0 0 9cffffff", en_o, step, pos, digits);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (!en_o && k < 20) begin @(posedge clk); #1; k++; end
        n_total++; if (k != 5) $display("FAIL rst_en_latency got=%0d exp=5", k); else n_pass++;
        k = 0;
        while (!step && k < 20) begin @(posedge clk); #1; k++; end
        n_total++; if (k != 4) $display("FAIL rst_first_step got=%0d exp=4", k); else n_pass++;
    endtask

    task automatic test_random();
        int hold_en = 1, hold_dir = 1;
        repeat (600) begin
            @(negedge clk);
            n_total++;
            if ({en_o, dir_o, step, pos, digits} !== {m_en, m_dir, m_step, m_pos, exp_digits(m_pos)})
                $display("FAIL rand_model got=%b%b%b %0d %h exp=%b%b%b %0d %h", en_o, dir_o, step, pos, digits,
                         m_en, m_dir, m_step, m_pos, exp_digits(m_pos));
            else n_pass++;
            if (--hold_en == 0) begin sw_en = 1'($urandom_range(0, 1)); hold_en = $urandom_range(1, 8); end
            if (--hold_dir == 0) begin sw_dir = 1'($urandom_range(0, 1)); hold_dir = $urandom_range(1, 8); end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_dir();
        test_glitch();
        test_pause();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
